// File: rtl/fetch_queue.sv
// Instruction fetch queue: a small FSM-driven PC sequencer that fetches one
// word per cycle from instruction memory into a DEPTH-entry circular buffer
// and presents the head entry to decode. Fetching stops after ebreak is
// queued and resumes on a branch redirect (flush).
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     flush,
  input  logic [XLEN-1:0]          flush_pc,
  output logic                     imem_rd_en,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [XLEN-1:0]          deq_inst,
  output logic [XLEN-1:0]          deq_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] EBREAK = XLEN'(32'h0010_0073);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic full;
  logic deq;
  logic fetch;

  // A full queue can still accept a fetch when the head leaves in the same
  // cycle, which is what sustains one instruction per cycle.
  assign full       = (count == CW'(DEPTH));
  assign deq_valid  = (count != '0) && !flush;
  assign deq        = deq_valid && deq_ready;
  assign fetch      = (state == RUN) && !flush && (!full || deq);
  assign imem_rd_en = fetch;
  assign imem_addr  = pc;
  assign deq_inst   = inst_mem[head];
  assign deq_pc     = pc_mem[head];

  // Control state: FSM, PC, pointers and occupancy; flush overrides all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      halted <= 1'b0;
      pc     <= RESET_PC;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          halted <= 1'b0;
          if (start) state <= RUN;
        end
        RUN: begin
          if (fetch && (imem_rdata == EBREAK)) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (flush) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          halted <= 1'b0;
        end
      endcase

      if (flush) begin
        pc    <= flush_pc & ~XLEN'(3);
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (fetch) begin
          pc   <= pc + XLEN'(4);
          tail <= tail + 1'b1;
        end
        if (deq) head <= head + 1'b1;
        if (fetch && !deq)      count <= count + 1'b1;
        else if (!fetch && deq) count <= count - 1'b1;
      end
    end
  end

  // Queue storage: data only, validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (fetch) begin
      inst_mem[tail] <= imem_rdata;
      pc_mem[tail]   <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [31:0] NO_EB    = 32'hFFFF_FF01;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic [2:0]  count;
  logic        halted;
  logic [31:0] ebreak_addr;

  int n_pass = 0;
  int n_chk  = 0;

  // reference model: 0 = idle, 1 = run, 2 = halt
  int          mst;
  logic [31:0] mpc;
  logic [63:0] mq[$];

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .flush_pc(flush_pc),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_inst(deq_inst),
    .deq_pc(deq_pc), .count(count), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr == ebreak_addr) ? EBREAK : imem_addr + 32'h100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    mst = 0;
    mpc = RESET_PC;
    mq.delete();
  endtask

  // One clock: entered just after a falling edge with inputs applied.
  task automatic cycle();
    logic        mdv;
    logic        mfet;
    logic [31:0] rd;
    #1;
    mdv  = (mq.size() != 0) && !flush;
    mfet = (mst == 1) && !flush && ((mq.size() < DEPTH) || (mdv && deq_ready));
    chk("rd_en",     32'(imem_rd_en), 32'(mfet));
    chk("addr",      imem_addr,       mpc);
    chk("count",     32'(count),      32'(mq.size()));
    chk("deq_valid", 32'(deq_valid),  32'(mdv));
    chk("halted",    32'(halted),     32'(mst == 2));
    if (mdv) begin
      chk("deq_inst", deq_inst, mq[0][63:32]);
      chk("deq_pc",   deq_pc,   mq[0][31:0]);
    end
    rd = (mpc == ebreak_addr) ? EBREAK : mpc + 32'h100;
    @(posedge clk);
    if (flush) begin
      mq.delete();
      mpc = flush_pc & ~32'h3;
    end else begin
      if (mdv && deq_ready) void'(mq.pop_front());
      if (mfet) begin
        mq.push_back({rd, mpc});
        mpc = mpc + 32'd4;
      end
    end
    if (mst == 0 && start)                    mst = 1;
    else if (mst == 2 && flush)               mst = 1;
    else if (mst == 1 && mfet && rd == EBREAK) mst = 2;
    @(negedge clk);
  endtask

  // Assert reset between edges and check its effect before any clock.
  task automatic async_reset();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_count",     32'(count),      32'd0);
    chk("rst_deq_valid", 32'(deq_valid),  32'd0);
    chk("rst_rd_en",     32'(imem_rd_en), 32'd0);
    chk("rst_halted",    32'(halted),     32'd0);
    chk("rst_addr",      imem_addr,       RESET_PC);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0; flush_pc = '0;
    deq_ready = 1'b0; ebreak_addr = NO_EB;
    model_reset();
    @(negedge clk);
    async_reset();

    // stays idle without start
    repeat (3) cycle();

    // streaming with deq_ready high
    start = 1'b1; deq_ready = 1'b1;
    repeat (8) cycle();
    chk("stream_count", 32'(count), 32'd1);

    // backpressure fills the queue, then drains in order
    async_reset();
    start = 1'b1; deq_ready = 1'b0;
    repeat (10) cycle();
    chk("full_count", 32'(count),      32'd4);
    chk("full_rd_en", 32'(imem_rd_en), 32'd0);
    deq_ready = 1'b1;
    repeat (5) cycle();

    // flush of a full queue with a misaligned target
    deq_ready = 1'b0;
    repeat (6) cycle();
    flush = 1'b1; flush_pc = 32'h0000_0203;
    cycle();
    flush = 1'b0;
    chk("flush_addr",  imem_addr,  32'h0000_0200);
    chk("flush_count", 32'(count), 32'd0);
    repeat (3) cycle();

    // ebreak at 0x8 halts fetching; flush restarts at 0x40
    async_reset();
    ebreak_addr = 32'h8;
    start = 1'b1; deq_ready = 1'b0;
    repeat (6) cycle();
    chk("halt_flag",  32'(halted), 32'd1);
    chk("halt_count", 32'(count),  32'd3);
    deq_ready = 1'b1;
    repeat (4) cycle();
    flush = 1'b1; flush_pc = 32'h40;
    cycle();
    flush = 1'b0;
    chk("redirect_addr", imem_addr, 32'h40);
    repeat (3) cycle();
    ebreak_addr = NO_EB;

    // reset mid-run with three entries queued
    async_reset();
    start = 1'b1; deq_ready = 1'b0;
    repeat (4) cycle();
    chk("pre_rst_count", 32'(count), 32'd3);
    async_reset();
    repeat (3) cycle();
    start = 1'b1;
    repeat (3) cycle();

    // PC wraps past the top of the address space
    deq_ready = 1'b1;
    flush = 1'b1; flush_pc = 32'hFFFF_FFF4;
    cycle();
    flush = 1'b0;
    repeat (3) cycle();
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    repeat (2) cycle();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      start     = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      flush_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 255));
      deq_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0)
        ebreak_addr = ($urandom_range(0, 7) == 0) ? NO_EB : 32'($urandom_range(0, 63) * 4);
      if ($urandom_range(0, 199) == 0) async_reset();
      else cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the PC and instruction width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning queue entries; it is a power of two and at least 2.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  level; fetching begins on the first cycle it is high while in IDLE.
REQ-007 flush  in  1  branch redirect, single-cycle pulse.
REQ-008 flush_pc  in  XLEN  redirect target.
REQ-009 imem_rd_en  out  1  instruction memory read enable.
REQ-010 imem_addr  out  XLEN  instruction memory address (current fetch PC).
REQ-011 imem_rdata  in  XLEN  instruction word, combinationally valid in the same cycle as imem_addr.
REQ-012 deq_valid  out  1  head entry available to decode.
REQ-013 deq_ready  in  1  decode accepts the head entry.
REQ-014 deq_inst  out  XLEN  head instruction.
REQ-015 deq_pc  out  XLEN  head instruction's PC.
REQ-016 count  out  log2(DEPTH)+1  number of valid entries.
REQ-017 halted  out  1  high in HALT state.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and HALT.
- IDLE->RUN when start=1.
- RUN->HALT when an enqueued word equals 32'h0010_0073 (ebreak).
- HALT->RUN on flush.
- IDLE ignores flush except for loading the PC.
REQ-019 A fetch SHALL occur in a cycle iff state=RUN, flush=0, and either count<DEPTH or (count=DEPTH and deq_valid&&deq_ready); imem_rd_en SHALL equal this fetch condition.
REQ-020 On a fetch, {imem_rdata, imem_addr} SHALL be written at the tail at the next edge, and the PC SHALL advance by 4, wrapping modulo 2^XLEN.
REQ-021 A dequeue SHALL occur when deq_valid&&deq_ready; the head pointer advances at the next edge.
REQ-022 deq_valid SHALL be (count!=0)&&!flush; deq_inst and deq_pc SHALL show the head entry combinationally.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-024 On a simultaneous fetch and dequeue, count SHALL remain unchanged; fetch-only increments count; dequeue-only decrements it.
REQ-025 On flush, at the next edge:
- count, head and tail SHALL clear;
- PC SHALL load flush_pc with bits [1:0] forced to 0;
- no fetch or dequeue occurs that cycle.
REQ-026 Flush SHALL take priority over fetch, dequeue and the HALT transition in the same cycle.
REQ-027 In HALT, queued entries SHALL remain dequeueable and no new fetch SHALL be issued.
REQ-028 A fetch issued in the same cycle that ebreak is enqueued SHALL be the last fetch, and ebreak SHALL itself be enqueued.
REQ-029 Fetch-to-deq_valid latency SHALL be one cycle; steady-state throughput SHALL be one instruction per cycle with deq_ready held high.

Reset
REQ-030 While reset=1, the block SHALL hold: state=IDLE, PC=RESET_PC, head=tail=0, count=0, deq_valid=0, imem_rd_en=0, halted=0, imem_addr=RESET_PC.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries immediately, without waiting for a clock edge.
REQ-032 After reset is released, the block SHALL remain in IDLE until start is asserted.

Verification
REQ-033 Reset, start=1, deq_ready=1, imem returns addr+0x100 -> deq_pc 0,4,8... on consecutive cycles from cycle 2; deq_inst=deq_pc+0x100; count stays 1.
REQ-034 deq_ready=0 for 10 cycles after start with DEPTH=4 -> imem_rd_en drops after 4 fetches; count=4; PCs 0..C queued; deq_ready=1 then yields 0,4,8,C,10 in order.
REQ-035 Queue full (count=4), flush with flush_pc=0x0000_0203 -> deq_valid=0 in the flush cycle; count=0 next edge; next imem_addr=0x200.
REQ-036 imem returns 0x0010_0073 at PC 0x8 -> halted=1 after that edge; no further imem_rd_en; entries 0,4,8 dequeued; flush to 0x40 -> RUN, fetch at 0x40.
REQ-037 Reset asserted mid-run with count=3 -> count=0 and deq_valid=0 immediately; after release, no fetch occurs until start=1, then the first imem_addr is RESET_PC.
REQ-038 PC=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
